// File: rtl/uart_txq_pkg.sv
// Shared types, widths and the checksum helper for the UART transmit message queue.
package uart_txq_pkg;

  localparam int unsigned MSG_W  = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitStart,
    StWaitDone,
    StGap
  } state_e;

  function automatic logic [BYTE_W-1:0] checksum(input logic [MSG_W-1:0] msg);
    return msg[MSG_W-1:BYTE_W] ^ msg[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/uart_tx_msg_queue_if.sv
// Message-side and transmitter-side handshake bundle for uart_tx_msg_queue.
interface uart_tx_msg_queue_if;
  import uart_txq_pkg::*;

  logic              msg_WR;
  logic [MSG_W-1:0]  msg_DATA;
  logic              msg_FULL;
  logic              msg_EMPTY;
  logic              msg_OVF;
  logic [BYTE_W-1:0] Tx_Data;
  logic              Tx_WR;
  logic              Tx_EN;
  logic              Tx_BUSY;
  logic              tx_ERR;

  // Environment side: system pusher plus the transmitter's busy flag.
  modport master (
    output msg_WR, msg_DATA, Tx_BUSY,
    input  msg_FULL, msg_EMPTY, msg_OVF, Tx_Data, Tx_WR, Tx_EN, tx_ERR
  );

  modport slave (
    input  msg_WR, msg_DATA, Tx_BUSY,
    output msg_FULL, msg_EMPTY, msg_OVF, Tx_Data, Tx_WR, Tx_EN, tx_ERR
  );

endinterface

// File: rtl/msg_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop in the same cycle frees a slot for a push.
module msg_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             wr_accept
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             rd_en;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_en     = rd && !empty;
  assign wr_accept = wr && (!full || rd_en);
  assign rdata     = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_accept) wptr_q <= wptr_q + 1'b1;
      if (rd_en)     rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_msg_queue.sv
// Buffers 16-bit messages and feeds them high byte first to the UART transmitter.
// Define UART_TXQ_CHECKSUM_EN to append an XOR checksum byte to every message.
module uart_tx_msg_queue
  import uart_txq_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned START_TIMEOUT = 65535
) (
  input logic               clk,
  input logic               reset,
  uart_tx_msg_queue_if.slave bus
);

`ifdef UART_TXQ_CHECKSUM_EN
  localparam logic [1:0] LastIdx = 2'd2;
`else
  localparam logic [1:0] LastIdx = 2'd1;
`endif
  localparam logic [15:0] TimeoutVal = 16'(START_TIMEOUT);

  state_e            state_q;
  logic [MSG_W-1:0]  msg_q;
  logic [1:0]        byte_idx_q;
  logic [15:0]       cnt_q, cnt_inc;
  logic [BYTE_W-1:0] tx_data_q, byte_sel;
  logic              tx_wr_q, tx_en_q, tx_err_q, ovf_q;
  logic              busy_meta_q, busy_sync_q, busy_prev_q, busy_rise, busy_fall;
  logic [MSG_W-1:0]  fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_wr_accept;

  msg_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(MSG_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr       (bus.msg_WR),
    .wdata    (bus.msg_DATA),
    .rd       (state_q == StIdle),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .wr_accept(fifo_wr_accept)
  );

  // Tx_BUSY comes from another clock domain; edges are taken after two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_meta_q <= 1'b0;
      busy_sync_q <= 1'b0;
      busy_prev_q <= 1'b0;
    end else begin
      busy_meta_q <= bus.Tx_BUSY;
      busy_sync_q <= busy_meta_q;
      busy_prev_q <= busy_sync_q;
    end
  end

  assign busy_rise = busy_sync_q && !busy_prev_q;
  assign busy_fall = !busy_sync_q && busy_prev_q;
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    byte_sel = msg_q[MSG_W-1:BYTE_W];
    case (byte_idx_q)
      2'd1: byte_sel = msg_q[BYTE_W-1:0];
`ifdef UART_TXQ_CHECKSUM_EN
      2'd2: byte_sel = checksum(msg_q);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      msg_q      <= '0;
      byte_idx_q <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_wr_q    <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      tx_wr_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            msg_q      <= fifo_rdata;
            byte_idx_q <= '0;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          tx_data_q <= byte_sel;
          tx_en_q   <= 1'b1;
          tx_wr_q   <= 1'b1;
          cnt_q     <= '0;
          state_q   <= StWaitStart;
        end
        StWaitStart: begin
          if (busy_rise) begin
            state_q <= StWaitDone;
          end else if (cnt_inc == TimeoutVal) begin
            // Abort: the rest of this message is skipped by jumping to the last index.
            cnt_q      <= cnt_inc;
            tx_err_q   <= 1'b1;
            tx_en_q    <= 1'b0;
            byte_idx_q <= LastIdx;
            state_q    <= StGap;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StWaitDone: begin
          if (busy_fall) begin
            tx_en_q <= 1'b0;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (byte_idx_q != LastIdx) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            state_q    <= StLoad;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (bus.msg_WR && !fifo_wr_accept) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.msg_FULL  = fifo_full;
  assign bus.msg_EMPTY = fifo_empty && (state_q == StIdle);
  assign bus.msg_OVF   = ovf_q;
  assign bus.Tx_Data   = tx_data_q;
  assign bus.Tx_WR     = tx_wr_q;
  assign bus.Tx_EN     = tx_en_q;
  assign bus.tx_ERR    = tx_err_q;

endmodule

// File: tb/tb_uart_tx_msg_queue.sv
// Directed and random stimulus for uart_tx_msg_queue against a byte-stream reference model.
module tb_uart_tx_msg_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 10;
`ifdef UART_TXQ_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_msg_queue_if bus ();

  uart_tx_msg_queue #(
    .DEPTH        (DEPTH),
    .START_TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int tx_delay = 3;
  int tx_hold = 20;
  bit tx_never = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: a message becomes high byte, low byte and optionally their XOR.
  task automatic add_msg(input logic [15:0] m);
    exp_q.push_back(8'(m >> 8));
    exp_q.push_back(8'(m & 16'h00FF));
    if (NB == 3) exp_q.push_back(8'(m >> 8) ^ 8'(m & 16'h00FF));
  endtask

  task automatic push(input logic [15:0] m);
    bus.msg_WR   = 1'b1;
    bus.msg_DATA = m;
    @(negedge clk);
    bus.msg_WR = 1'b0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 200 && bus.Tx_BUSY !== 1'b0; i++) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    got.delete();
    exp_q.delete();
  endtask

  task automatic wait_wr(input string tag);
    int i;
    for (i = 0; i < 100; i++) begin
      if (bus.Tx_WR === 1'b1) break;
      @(negedge clk);
    end
    check({"wr_seen_", tag}, 32'(i < 100), 1);
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.msg_EMPTY === 1'b1 && bus.Tx_BUSY === 1'b0 && bus.Tx_EN === 1'b0) break;
    end
    check({"drain_", tag}, 32'(i < 3000), 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic compare_got(input string tag);
    check({"nbytes_", tag}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("byte%0d_%s", i, tag), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  // Monitor: capture every byte write.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.Tx_WR === 1'b1) begin
        got.push_back(bus.Tx_Data);
        check("en_with_wr", bus.Tx_EN, 1);
      end
    end
  end

  // Transmitter model: busy rises tx_delay cycles after Tx_WR and stays up tx_hold cycles.
  initial begin
    bus.Tx_BUSY = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.Tx_WR === 1'b1 && !tx_never) begin
        repeat (tx_delay) @(negedge clk);
        bus.Tx_BUSY = 1'b1;
        for (int k = 0; k < tx_hold; k++) @(negedge clk);
        bus.Tx_BUSY = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int c;
    int cnt;
    logic [15:0] m;
    bus.msg_WR   = 1'b0;
    bus.msg_DATA = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check("rst_full", bus.msg_FULL, 0);
    check("rst_empty", bus.msg_EMPTY, 1);
    check("rst_ovf", bus.msg_OVF, 0);
    check("rst_data", bus.Tx_Data, 0);
    check("rst_wr", bus.Tx_WR, 0);
    check("rst_en", bus.Tx_EN, 0);
    check("rst_err", bus.tx_ERR, 0);

    // Single message, push-to-write latency.
    push(16'hA1B2);
    check("push_empty", bus.msg_EMPTY, 0);
    for (lat = 0; lat < 50; lat++) begin
      if (bus.Tx_WR === 1'b1) break;
      @(negedge clk);
    end
    check("wr_latency", lat, 2);
    add_msg(16'hA1B2);
    drain("single");
    check("single_empty", bus.msg_EMPTY, 1);
    compare_got("single");

    // Start timeout, then recovery on the next message.
    do_reset();
    tx_never = 1'b1;
    push(16'h5A3C);
    wait_wr("tmo");
    for (c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.tx_ERR === 1'b1) break;
    end
    check("tmo_cycle", c, TMO);
    check("tmo_en", bus.Tx_EN, 0);
    exp_q.push_back(8'h5A);
    tx_never = 1'b0;
    repeat (3) @(negedge clk);
    push(16'hC3E1);
    add_msg(16'hC3E1);
    drain("tmo");
    check("tmo_sticky", bus.tx_ERR, 1);
    compare_got("tmo");

    // Reset while the first byte is in flight.
    do_reset();
    tx_delay = 3;
    tx_hold  = 20;
    push(16'h1234);
    wait_wr("rst");
    repeat (8) @(negedge clk);
    check("mid_en", bus.Tx_EN, 1);
    reset = 1'b0;
    #1;
    check("async_en", bus.Tx_EN, 0);
    check("async_empty", bus.msg_EMPTY, 1);
    check("async_full", bus.msg_FULL, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    exp_q.push_back(8'h12);
    compare_got("rst_mid");

    // Fill while stalled, push+pop on a full FIFO, then a dropped push.
    do_reset();
    tx_hold = 100000;
    push(16'h0001);
    wait_wr("fill");
    add_msg(16'h0001);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      push(16'(i + 2));
      if (cnt < int'(DEPTH)) begin
        cnt++;
        add_msg(16'(i + 2));
      end
      check($sformatf("fill_full%0d", i), bus.msg_FULL, 32'(cnt == int'(DEPTH)));
      check($sformatf("fill_ovf%0d", i), bus.msg_OVF, 0);
    end
    tx_hold = 20;
    for (c = 0; c < 500 && got.size() < NB; c++) @(negedge clk);
    check("fill_lastbyte", 32'(c < 500), 1);
    for (c = 0; c < 500; c++) begin
      if (bus.Tx_EN === 1'b0) break;
      @(negedge clk);
    end
    check("fill_en_fall", 32'(c < 500), 1);
    @(negedge clk);
    push(16'h0006);
    add_msg(16'h0006);
    check("pp_ovf", bus.msg_OVF, 0);
    check("pp_full", bus.msg_FULL, 1);
    push(16'h0007);
    check("drop_ovf", bus.msg_OVF, 1);
    check("drop_full", bus.msg_FULL, 1);
    drain("fill");
    compare_got("fill");

    // Random stream through the wrapping pointers.
    do_reset();
    for (int n = 0; n < 10; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      tx_delay = $urandom_range(1, 4);
      tx_hold  = $urandom_range(1, 8);
      for (c = 0; c < 2000 && bus.msg_FULL !== 1'b0; c++) @(negedge clk);
      m = 16'($urandom);
      push(m);
      add_msg(m);
    end
    drain("rand");
    check("rand_ovf", bus.msg_OVF, 0);
    compare_got("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
